pudding_dac_sequencer: RTL and testbench

Sequencer for the 128-source unary current-steering DAC. It replaces serial shifting of the DAC state word with on-chip level control. A small register file sets a target level, slew step and update rate. An FSM then ramps the DAC level, either once to the target or as a continuous triangle sweep between two levels. Each level is decoded to the 128-bit thermometer switch word that drives the DAC ON inputs, plus the DAC enable.

---
 rtl/pudding_dac_sequencer.sv | 178 +++++++++++++++++
 tb/tb_pudding_dac_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pudding_dac_sequencer.sv
// Level sequencer for the unary current-steering DAC: slew/triangle ramp FSM plus thermometer decode.
// Define PUDDING_DWA_EN to rotate the thermometer word by a data-weighted-averaging pointer.
module pudding_dac_sequencer #(
   parameter int N  = 128,
   parameter int LW = $clog2(N) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_cfg_we,
   input  logic [2:0]    i_cfg_addr,
   input  logic [7:0]    i_cfg_wdata,
   input  logic          i_trig,
   output logic [N-1:0]  o_on,
   output logic          o_en,
   output logic [LW-1:0] o_level,
   output logic          o_busy,
   output logic          o_done
);

   localparam int AW = ((LW > 8) ? LW : 8) + 1;
   localparam logic [LW-1:0] LVL_MAX = LW'(N);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_UP   = 2'd1;
   localparam logic [1:0] ST_DOWN = 2'd2;

   logic [1:0]    r_ctrl;
   logic [7:0]    r_lo;
   logic [7:0]    r_hi;
   logic [7:0]    r_step;
   logic [7:0]    r_div;
   logic [7:0]    r_cnt;
   logic [1:0]    r_state;
   logic [LW-1:0] r_level;
   logic          r_done;
   logic          r_en;
   logic          r_upd;
   logic [N-1:0]  r_on;

   logic [LW-1:0] w_lo;
   logic [LW-1:0] w_hi;
   logic [7:0]    w_step;
   logic          w_tri;
   logic [LW-1:0] w_tgt;
   logic [AW-1:0] w_sum;
   logic [LW-1:0] w_up;
   logic [LW-1:0] w_dn;
   logic [1:0]    w_state_d;
   logic [LW-1:0] w_level_d;
   logic [7:0]    w_cnt_d;
   logic          w_done_d;
   logic [N-1:0]  w_therm;
   logic [N-1:0]  w_on_d;

   assign w_lo   = (32'(r_lo) > N) ? LVL_MAX : LW'(r_lo);
   assign w_hi   = (32'(r_hi) > N) ? LVL_MAX : LW'(r_hi);
   assign w_step = (r_step == 8'd0) ? 8'd1 : r_step;
   // Triangle with an empty or inverted band degenerates to a plain slew to HI.
   assign w_tri  = r_ctrl[1] && (w_lo < w_hi);
   assign w_tgt  = w_tri ? w_lo : w_hi;

   assign w_sum = AW'(r_level) + AW'(w_step);
   assign w_up  = (w_sum > AW'(w_hi)) ? w_hi : LW'(w_sum);
   assign w_dn  = (AW'(r_level) < AW'(w_tgt) + AW'(w_step)) ? w_tgt
                                                            : r_level - LW'(w_step);

   always_comb begin
      w_state_d = r_state;
      w_level_d = r_level;
      w_cnt_d   = r_cnt;
      w_done_d  = 1'b0;
      if (r_state == ST_IDLE) begin
         if (i_trig) begin
            w_cnt_d = '0;
            if (r_level < w_hi) begin
               w_state_d = ST_UP;
            end else if (r_level > w_hi) begin
               w_state_d = ST_DOWN;
            end else begin
               w_done_d = 1'b1;
            end
         end
      end else if (i_trig) begin
         w_state_d = ST_IDLE;
      end else if (r_cnt != r_div) begin
         w_cnt_d = r_cnt + 8'd1;
      end else begin
         w_cnt_d = '0;
         if (r_state == ST_UP) begin
            w_level_d = w_up;
            if (w_up == w_hi) begin
               if (w_tri) begin
                  w_state_d = ST_DOWN;
               end else begin
                  w_state_d = ST_IDLE;
                  w_done_d  = 1'b1;
               end
            end
         end else if (r_state == ST_DOWN) begin
            w_level_d = w_dn;
            if (w_dn == w_tgt) begin
               if (w_tri) begin
                  w_state_d = ST_UP;
               end else begin
                  w_state_d = ST_IDLE;
                  w_done_d  = 1'b1;
               end
            end
         end else begin
            w_state_d = ST_IDLE;
         end
      end
   end

   // Shifting by level == N clears everything, giving the all-ones word.
   assign w_therm = ~({N{1'b1}} << r_level);

`ifdef PUDDING_DWA_EN
   localparam int PW = $clog2(N);
   logic [PW-1:0] r_ptr;

   assign w_on_d = (w_therm << r_ptr) | (w_therm >> (N - 32'(r_ptr)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (r_upd) begin
         r_ptr <= r_ptr + PW'(r_level);
      end
   end
`else
   assign w_on_d = w_therm;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ctrl  <= '0;
         r_lo    <= '0;
         r_hi    <= '0;
         r_step  <= 8'd1;
         r_div   <= '0;
         r_cnt   <= '0;
         r_state <= ST_IDLE;
         r_level <= '0;
         r_done  <= 1'b0;
         r_en    <= 1'b0;
         r_upd   <= 1'b0;
         r_on    <= '0;
      end else begin
         r_cnt   <= w_cnt_d;
         r_state <= w_state_d;
         r_level <= w_level_d;
         r_done  <= w_done_d;
         r_en    <= r_ctrl[0];
         r_upd   <= (w_level_d != r_level);
         if (r_upd) begin
            r_on <= w_on_d;
         end
         if (i_cfg_we) begin
            case (i_cfg_addr)
               3'd0:    r_ctrl <= i_cfg_wdata[1:0];
               3'd1:    r_lo   <= i_cfg_wdata;
               3'd2:    r_hi   <= i_cfg_wdata;
               3'd3:    r_step <= i_cfg_wdata;
               3'd4:    r_div  <= i_cfg_wdata;
               default: ;
            endcase
         end
      end
   end

   assign o_on    = r_on;
   assign o_en    = r_en;
   assign o_level = r_level;
   assign o_busy  = (r_state != ST_IDLE);
   assign o_done  = r_done;

endmodule

// File: tb/tb_pudding_dac_sequencer.sv
// Randomized plus directed bench for pudding_dac_sequencer against an integer reference model.
module tb_pudding_dac_sequencer;

   localparam int N  = 128;
   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          i_cfg_we = 1'b0;
   logic [2:0]    i_cfg_addr = '0;
   logic [7:0]    i_cfg_wdata = '0;
   logic          i_trig = 1'b0;
   logic [N-1:0]  o_on;
   logic          o_en;
   logic [LW-1:0] o_level;
   logic          o_busy;
   logic          o_done;

   pudding_dac_sequencer #(.N(N), .LW(LW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_cfg_we    (i_cfg_we),
      .i_cfg_addr  (i_cfg_addr),
      .i_cfg_wdata (i_cfg_wdata),
      .i_trig      (i_trig),
      .o_on        (o_on),
      .o_en        (o_en),
      .o_level     (o_level),
      .o_busy      (o_busy),
      .o_done      (o_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: plain integers, dir = +1 ramping up, -1 ramping down, 0 idle.
   int           m_ctrl, m_lo, m_hi, m_step, m_div, m_level, m_dir, m_cnt, m_ptr;
   bit           m_done, m_en, m_pend;
   logic [N-1:0] m_on;

   function automatic logic [N-1:0] therm(input int l);
      logic [N-1:0] r = '0;
      for (int i = 0; i < l; i++) r[i] = 1'b1;
      return r;
   endfunction

   function automatic logic [N-1:0] rotl(input logic [N-1:0] x, input int p);
      logic [N-1:0] r = '0;
      for (int i = 0; i < N; i++) r[(i + p) % N] = x[i];
      return r;
   endfunction

   task automatic model_reset();
      m_ctrl = 0; m_lo = 0; m_hi = 0; m_step = 1; m_div = 0;
      m_level = 0; m_dir = 0; m_cnt = 0; m_ptr = 0;
      m_done = 0; m_en = 0; m_pend = 0; m_on = '0;
   endtask

   task automatic model_edge(input bit we, input int addr, input int wdata, input bit trig);
      int lo, hi, st, tgt, nl;
      bit tri_on;
      lo = (m_lo > N) ? N : m_lo;
      hi = (m_hi > N) ? N : m_hi;
      st = (m_step == 0) ? 1 : m_step;
      tri_on = ((m_ctrl & 2) != 0) && (lo < hi);
      tgt = tri_on ? lo : hi;
      if (m_pend) begin
         m_on = rotl(therm(m_level), m_ptr);
`ifdef PUDDING_DWA_EN
         m_ptr = (m_ptr + m_level) % N;
`endif
      end
      nl = m_level;
      m_done = 0;
      if (m_dir == 0) begin
         if (trig) begin
            m_cnt = 0;
            if (m_level < hi) m_dir = 1;
            else if (m_level > hi) m_dir = -1;
            else m_done = 1;
         end
      end else if (trig) begin
         m_dir = 0;
      end else if (m_cnt == m_div) begin
         m_cnt = 0;
         if (m_dir == 1) begin
            nl = (m_level + st > hi) ? hi : m_level + st;
            if (nl == hi) begin
               if (tri_on) m_dir = -1;
               else begin m_dir = 0; m_done = 1; end
            end
         end else begin
            nl = (m_level - st < tgt) ? tgt : m_level - st;
            if (nl == tgt) begin
               if (tri_on) m_dir = 1;
               else begin m_dir = 0; m_done = 1; end
            end
         end
      end else begin
         m_cnt++;
      end
      m_pend = (nl != m_level);
      m_level = nl;
      m_en = m_ctrl[0];
      if (we) begin
         case (addr)
            0: m_ctrl = wdata;
            1: m_lo = wdata;
            2: m_hi = wdata;
            3: m_step = wdata;
            4: m_div = wdata;
            default: ;
         endcase
      end
   endtask

   task automatic cycle(input bit we, input int addr, input int wdata, input bit trig);
      i_cfg_we = we;
      i_cfg_addr = addr[2:0];
      i_cfg_wdata = wdata[7:0];
      i_trig = trig;
      @(posedge clk);
      model_edge(we, addr, wdata, trig);
      #1;
      check("level", o_level, m_level);
      check("busy", o_busy, m_dir != 0);
      check("done", o_done, m_done);
      check("on", o_on, m_on);
      check("en", o_en, m_en);
      i_cfg_we = 1'b0;
      i_trig = 1'b0;
   endtask

   task automatic wr(input int addr, input int data);
      cycle(1'b1, addr, data, 1'b0);
   endtask

   task automatic trg();
      cycle(1'b0, 0, 0, 1'b1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_level", o_level, 0);
      check("rst_on", o_on, 0);
      check("rst_en", o_en, 0);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   int           up_exp[4]  = '{3, 6, 9, 10};
   int           tri_exp[8] = '{1, 2, 3, 4, 3, 2, 1, 2};
   int           held;
   int           r, a, d;
   logic [N-1:0] all_ones;
   logic [N-1:0] dwa_exp;

   initial begin
      all_ones = '1;
`ifdef PUDDING_DWA_EN
      dwa_exp = 128'hF8;
`else
      dwa_exp = 128'h1F;
`endif
      #2;
      do_reset();

      // Slew up
      wr(2, 10); wr(3, 3);
      trg();
      check("up_busy", o_busy, 1);
      for (int i = 0; i < 4; i++) begin
         idle(1);
         check("up_level", o_level, up_exp[i]);
      end
      check("up_done", o_done, 1);
      check("up_busy_fall", o_busy, 0);
      idle(1);
      check("up_on", o_on, 128'h3FF);

      // Slew down
      wr(2, 2); wr(3, 4);
      trg();
      idle(1);
      check("dn_level6", o_level, 6);
      idle(1);
      check("dn_level2", o_level, 2);
      check("dn_done", o_done, 1);
      idle(1);
      check("dn_on", o_on, 128'h3);

      // Triangle then abort
      do_reset();
      wr(0, 3); wr(1, 1); wr(2, 4); wr(3, 1); wr(4, 1);
      trg();
      for (int j = 0; j < 8; j++) begin
         idle(2);
         check("tri_level", o_level, tri_exp[j]);
      end
      trg();
      check("abort_busy", o_busy, 0);
      held = int'(o_level);
      idle(4);
      check("abort_hold", o_level, held);

      // Clamp and degenerate values
      wr(0, 1); wr(1, 0); wr(2, 200); wr(3, 0); wr(4, 0);
      trg();
      idle(130);
      check("clamp_level", o_level, 128);
      check("clamp_on", o_on, all_ones);
      trg();
      check("eq_done", o_done, 1);
      check("eq_busy", o_busy, 0);

      // Thermometer / rotation
      do_reset();
      wr(2, 3); wr(3, 3);
      trg();
      idle(2);
      check("dwa_on1", o_on, 128'h7);
      wr(2, 5); wr(3, 2);
      trg();
      idle(2);
      check("dwa_on2", o_on, dwa_exp);

      // Reset mid-UP
      wr(2, 100); wr(4, 3);
      trg();
      idle(10);
      check("mid_busy", o_busy, 1);
      do_reset();
      trg();
      check("post_rst_done", o_done, 1);
      check("post_rst_busy", o_busy, 0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 999));
         if (r == 0) begin
            do_reset();
         end else if (r < 30) begin
            trg();
         end else if (r < 200) begin
            a = int'($urandom_range(0, 7));
            case (a)
               1, 2:    d = int'($urandom_range(0, 200));
               3:       d = int'($urandom_range(0, 6));
               4:       d = int'($urandom_range(0, 3));
               default: d = int'($urandom_range(0, 255));
            endcase
            wr(a, d);
         end else begin
            idle(1);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
